dac_scheduler: RTL
==================

DAC_SCHEDULER -- requirements
Module: dac_scheduler

Interface
REQ-001 Parameter: TIMEOUT, 15, max cycles to wait for dac_idle to fall after a trigger (range 1..255).
REQ-002 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: wr_en  input  1  host write strobe, one update per asserted cycle.
REQ-005 Port: wr_addr  input  3  target DAC channel 0..7.
REQ-006 Port: wr_data  input  12  new channel code.
REQ-007 Port: dac_idle  input  1  driver idle flag (chip-select deasserted); high = ready for a trigger.
REQ-008 Port: dac_address  output  3  channel handed to the driver, registered.
REQ-009 Port: dac_value  output  12  code handed to the driver, registered.
REQ-010 Port: dac_trigger  output  1  one-cycle start pulse to the driver, registered.
REQ-011 Port: pending  output  8  per-channel update-outstanding flags.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: done  output  1  one-cycle pulse when a transfer completes.
REQ-014 Port: err  output  1  sticky timeout flag, cleared only by reset.

Function
REQ-015 Eight 12-bit shadow registers SHALL hold the latest written code per channel; a write at an edge sets shadow[wr_addr]=wr_data and pending[wr_addr]=1.
REQ-016 Writes to an already-pending channel SHALL coalesce: shadow is overwritten, and only the newest value is ever transferred.
REQ-017 Write acceptance SHALL be unconditional in every state; there is no backpressure on the write port.
REQ-018 The state machine SHALL have three states: IDLE, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE, when pending!=0 and dac_idle=1: select a channel round-robin starting at last_served+1 mod 8. At the edge, register dac_address=sel, dac_value=shadow[sel] and dac_trigger=1, clear pending[sel], clear the timeout counter, and go to WAIT_BUSY.
REQ-020 dac_trigger SHALL be high for exactly one cycle per issued transfer and low in all other cycles.
REQ-021 If a write to sel coincides with the issue edge, the issued value SHALL be the pre-write shadow, and pending[sel] SHALL end set, so the new value is reissued later.
REQ-022 WAIT_BUSY: when dac_idle=0, go to WAIT_DONE. Otherwise increment the 8-bit counter. When the counter reaches TIMEOUT, set err=1, set last_served=sel, and return to IDLE without done.
REQ-023 WAIT_DONE: when dac_idle=1, pulse done=1 for one cycle, set last_served=sel, and return to IDLE.
REQ-024 IDLE with pending=0 or dac_idle=0 SHALL hold all outputs unchanged except dac_trigger=0.
REQ-025 Latency: a write sampled at edge k into an idle scheduler with dac_idle=1 SHALL produce dac_trigger=1 in the cycle after edge k+1.
REQ-026 dac_address and dac_value SHALL stay stable from the issue edge until the next issue edge.
REQ-027 Round-robin SHALL guarantee that every pending channel is served within 8 transfers, regardless of write traffic on other channels.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE with dac_trigger=0, dac_address=0, dac_value=0, pending=0, all shadows=0, busy=0, done=0, err=0, counter=0 and last_served=7.
REQ-029 Reset mid-transfer SHALL discard all pending updates and release dac_trigger asynchronously.
REQ-030 The first transfer after reset SHALL start on the first edge after rst_n rises at which the IDLE issue conditions hold.

Verification
REQ-031 Single write ch5=12, driver model drops dac_idle 1 cycle after trigger and raises it 60 cycles later -> one trigger pulse with address 5 and value 12, busy high throughout, one done pulse, pending=0.
REQ-032 Writes to ch2=0x100 then ch2=0x200 before the first issue -> one transfer only, with value 0x200.
REQ-033 Writes to ch0, ch3 and ch7 in the same idle window -> transfers issued in order 0, 3, 7; then a write to ch1 after ch7 -> ch1 issued next.
REQ-034 Write to ch4 coinciding with the ch4 issue edge (old value 0x010, new value 0x020) -> transfer with 0x010, pending[4]=1, then a second transfer with 0x020.
REQ-035 Driver model holds dac_idle=1 after trigger (TIMEOUT=15) -> err=1 sixteen cycles after the trigger, no done pulse, and the scheduler proceeds to the next pending channel.
REQ-036 rst_n asserted while in WAIT_DONE with 3 channels pending -> all outputs at reset values, no trigger after release until a new write.

Source files
------------

// File: rtl/dac_scheduler.sv
// -----------------------------------------------------------------------------
// dac_scheduler
//
// Collects per-channel code updates from a host write port into eight 12-bit
// shadow registers and hands them, one at a time, to a single-channel DAC
// driver. Channels with an outstanding update are served round-robin, starting
// after the channel most recently served. Repeated writes to a channel that
// has not been issued yet coalesce, so only the newest code is transferred.
//
// Driver handshake: in IDLE, when at least one channel is pending and
// dac_idle=1, a one-cycle dac_trigger is issued together with a registered
// dac_address/dac_value. The driver acknowledges by dropping dac_idle
// (transfer running) and completes by raising it again. If dac_idle never
// falls within TIMEOUT cycles, err latches and the scheduler moves on.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   wr_en        host write strobe, one update per asserted cycle
//   wr_addr[2:0] target channel
//   wr_data[11:0] new channel code
//   dac_idle     driver idle flag, high = ready for a trigger
//   dac_address  channel handed to the driver (registered)
//   dac_value    code handed to the driver (registered)
//   dac_trigger  one-cycle start pulse (registered)
//   pending      per-channel update-outstanding flags
//   busy         high whenever the FSM is not in IDLE
//   done         one-cycle pulse when a transfer completes
//   err          sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module dac_scheduler #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [11:0] wr_data,
    input  logic        dac_idle,
    output logic [2:0]  dac_address,
    output logic [11:0] dac_value,
    output logic        dac_trigger,
    output logic [7:0]  pending,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [11:0] shadow [8];
    logic [2:0]  last_served;
    logic [7:0]  cnt;
    logic [2:0]  sel;
    logic        sel_valid;
    logic [2:0]  idx;

    assign busy = (state != IDLE);

    // Round-robin pick: first pending channel scanning upward from
    // last_served+1, wrapping; last_served itself is checked last.
    always_comb begin
        sel       = last_served;
        sel_valid = 1'b0;
        idx       = last_served;
        for (int i = 1; i <= 8; i++) begin
            idx = last_served + 3'(i);
            if (!sel_valid && pending[idx]) begin
                sel       = idx;
                sel_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dac_address <= 3'd0;
            dac_value   <= 12'd0;
            dac_trigger <= 1'b0;
            pending     <= 8'd0;
            done        <= 1'b0;
            err         <= 1'b0;
            cnt         <= 8'd0;
            last_served <= 3'd7;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 12'd0;
            end
        end else begin
            dac_trigger <= 1'b0;
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_valid && dac_idle) begin
                        dac_address  <= sel;
                        dac_value    <= shadow[sel];
                        dac_trigger  <= 1'b1;
                        pending[sel] <= 1'b0;
                        cnt          <= 8'd0;
                        state        <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!dac_idle) begin
                        state <= WAIT_DONE;
                    end else if (cnt == 8'(TIMEOUT)) begin
                        err         <= 1'b1;
                        last_served <= dac_address;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (dac_idle) begin
                        done        <= 1'b1;
                        last_served <= dac_address;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so a write landing on the issue edge wins
            // over the pending clear: the new code is reissued later, while
            // the issued value above still reads the pre-write shadow.
            if (wr_en) begin
                shadow[wr_addr]  <= wr_data;
                pending[wr_addr] <= 1'b1;
            end
        end
    end

endmodule
